spawn_ctrl: RTL and testbench
=============================

SPAWN_CTRL -- requirements
Module: spawn_ctrl

Interface
REQ-001 Parameter N_SLOTS, 4, number of independent spawn slots (1..16).
REQ-002 Parameter DATA_W, 8, width of request data word.
REQ-003 Parameter LIFE_W, 10, lifetime counter width.
REQ-004 Parameter LIFETIME, 600, ticks a slot stays active (1..2^LIFE_W-1).
REQ-005 Parameter COOLDOWN, 30, ticks after a spawn during which requests are rejected (0 = none).
REQ-006 clk  in  1  system clock, all logic rising-edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 data_valid  in  1  request strobe, one-cycle pulse per data word.
REQ-009 data  in  DATA_W  request word; nonzero = spawn request, value stored as slot type.
REQ-010 tick  in  1  frame-rate enable, one-cycle pulse.
REQ-011 despawn  in  N_SLOTS  per-slot kill (e.g. collision), level sampled each clk.
REQ-012 clear  in  1  synchronous flush of all slots and cooldown.
REQ-013 active  out  N_SLOTS  slot occupied flags (successor of single rectangle flag).
REQ-014 slot_type  out  N_SLOTS*DATA_W  stored type per slot, slot i at bits [i*DATA_W +: DATA_W].
REQ-015 spawned  out  1  one-cycle pulse when a request is accepted.
REQ-016 dropped  out  1  one-cycle pulse when a nonzero request is rejected (full or cooldown).
REQ-017 drop_cnt  out  8  saturating count of rejected requests.

Function
REQ-018 Request = data_valid && data != 0; data == 0 with data_valid SHALL be ignored, no pulse.
REQ-019 Accepted request SHALL occupy lowest-index slot with active==0 as registered at that edge; active, slot_type, spawned visible 1 cycle after request (latency 1).
REQ-020 New slot SHALL load life counter = LIFETIME and slot_type = data.
REQ-021 On tick, every active slot SHALL decrement its life counter; slot reaching 0 SHALL clear active on that same edge.
REQ-022 Slot accepted on the cycle of a tick SHALL NOT decrement on that tick.
REQ-023 despawn[i] high SHALL clear active[i] next edge; despawn has priority over tick decrement.
REQ-024 Slot freed (despawn/expiry) in cycle N SHALL be allocatable no earlier than cycle N+1.
REQ-025 All slots active at request -> request rejected, dropped pulses, drop_cnt+1 saturating at 255.
REQ-026 Cooldown FSM: states READY, COOL; READY + accepted request -> COOL with cool counter = COOLDOWN (stay READY if COOLDOWN==0).
REQ-027 COOL: counter decrements on tick; reaching 0 -> READY on that edge; request in COOL rejected as in REQ-025.
REQ-028 clear SHALL on next edge zero active, slot_type, life counters, return FSM to READY; drop_cnt retained; a request in the same cycle as clear SHALL be ignored without pulse.
REQ-029 slot_type of an inactive slot SHALL read 0.

Reset
REQ-030 rst_n low SHALL immediately clear active, slot_type, life/cool counters, spawned, dropped, drop_cnt; FSM to READY.
REQ-031 Reset asserted mid-lifetime or mid-cooldown SHALL abandon state; first request after deassertion SHALL be accepted into slot 0.
REQ-032 All outputs registered; no combinational path input->output.

Structure
REQ-033 Package spawn_pkg SHALL hold cooldown state enum (READY, COOL) and default parameter constants.
REQ-034 One sub-module spawn_slot (single slot: active, type, life counter, load/tick/kill/clear) SHALL be instantiated N_SLOTS times via generate.
REQ-035 Free-slot priority encoder SHALL reside in spawn_ctrl.

Verification
REQ-036 Reset, request data=8'h05 -> next cycle active=4'b0001, slot_type[7:0]=8'h05, spawned=1 one cycle.
REQ-037 LIFETIME=3, COOLDOWN=0: spawn then 3 ticks -> active[0] clears on edge of 3rd tick; tick coincident with spawn not counted.
REQ-038 COOLDOWN=0, 5 requests with 4 slots -> active=4'b1111, 5th gives dropped=1, drop_cnt=1; 300 further drops -> drop_cnt=255.
REQ-039 COOLDOWN=2: request, request (no tick) -> second dropped; after 2 ticks request accepted into slot 1.
REQ-040 Slots 0..2 active, despawn=4'b0010 with simultaneous request -> request takes slot 3; next request takes slot 1.
REQ-041 clear with request same cycle -> active=0, no spawned pulse, drop_cnt unchanged; rst_n low mid-cooldown -> outputs 0 immediately.

Source files
------------

// File: rtl/spawn_pkg.sv
// Shared types and default constants for the spawn controller and its slots.
package spawn_pkg;

  typedef enum logic {
    READY = 1'b0,
    COOL  = 1'b1
  } cool_state_e;

  localparam int DEF_N_SLOTS  = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_LIFE_W   = 10;
  localparam int DEF_LIFETIME = 600;
  localparam int DEF_COOLDOWN = 30;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      return 8'hFF;
    end else begin
      return value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/spawn_slot.sv
// One spawn slot: occupancy flag, stored type and a lifetime counter that
// counts down on frame ticks.
module spawn_slot
  import spawn_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LIFE_W   = DEF_LIFE_W,
  parameter int LIFETIME = DEF_LIFETIME
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  input  logic              tick,
  input  logic              kill,
  input  logic              clear,
  output logic              active,
  output logic [DATA_W-1:0] slot_type
);

  logic              active_r;
  logic [DATA_W-1:0] type_r;
  logic [LIFE_W-1:0] life_r;

  // Slot state: load only ever targets a free slot, so it cannot pre-empt a kill of a live object.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r <= 1'b0;
      type_r   <= {DATA_W{1'b0}};
      life_r   <= {LIFE_W{1'b0}};
    end else if (clear) begin
      active_r <= 1'b0;
      type_r   <= {DATA_W{1'b0}};
      life_r   <= {LIFE_W{1'b0}};
    end else if (load) begin
      active_r <= 1'b1;
      type_r   <= data;
      life_r   <= LIFE_W'(LIFETIME);
    end else if (kill) begin
      active_r <= 1'b0;
      type_r   <= {DATA_W{1'b0}};
      life_r   <= {LIFE_W{1'b0}};
    end else if (tick && active_r) begin
      if (life_r <= LIFE_W'(1)) begin
        active_r <= 1'b0;
        type_r   <= {DATA_W{1'b0}};
        life_r   <= {LIFE_W{1'b0}};
      end else begin
        life_r <= life_r - LIFE_W'(1);
      end
    end else begin
      life_r <= life_r;
    end
  end

  assign active    = active_r;
  assign slot_type = type_r;

endmodule

// File: rtl/spawn_ctrl.sv
// Spawn controller: allocates requests to the lowest free slot, enforces a
// post-spawn cooldown and counts rejected requests.
module spawn_ctrl
  import spawn_pkg::*;
#(
  parameter int N_SLOTS  = DEF_N_SLOTS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LIFE_W   = DEF_LIFE_W,
  parameter int LIFETIME = DEF_LIFETIME,
  parameter int COOLDOWN = DEF_COOLDOWN
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      data_valid,
  input  logic [DATA_W-1:0]         data,
  input  logic                      tick,
  input  logic [N_SLOTS-1:0]        despawn,
  input  logic                      clear,
  output logic [N_SLOTS-1:0]        active,
  output logic [N_SLOTS*DATA_W-1:0] slot_type,
  output logic                      spawned,
  output logic                      dropped,
  output logic [7:0]                drop_cnt
);

  localparam int COOL_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  logic [N_SLOTS-1:0] active_s;
  logic [N_SLOTS-1:0] free_s;
  logic [N_SLOTS-1:0] grant_s;
  logic [N_SLOTS-1:0] load_s;
  logic               req_s;
  logic               accept_s;
  logic               reject_s;

  cool_state_e        state_r;
  logic [COOL_W-1:0]  cool_r;
  logic               spawned_r;
  logic               dropped_r;
  logic [7:0]         drop_cnt_r;

  // Request qualification and lowest-index free-slot priority encoder.
  always_comb begin
    req_s    = data_valid && (data != {DATA_W{1'b0}}) && !clear;
    free_s   = ~active_s;
    grant_s  = free_s & (~free_s + N_SLOTS'(1'b1));
    accept_s = req_s && (|free_s) && (state_r == READY);
    reject_s = req_s && !accept_s;
    if (accept_s) begin
      load_s = grant_s;
    end else begin
      load_s = {N_SLOTS{1'b0}};
    end
  end

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    spawn_slot #(
      .DATA_W  (DATA_W),
      .LIFE_W  (LIFE_W),
      .LIFETIME(LIFETIME)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_s[g]),
      .data     (data),
      .tick     (tick),
      .kill     (despawn[g]),
      .clear    (clear),
      .active   (active_s[g]),
      .slot_type(slot_type[g*DATA_W +: DATA_W])
    );
  end

  // Cooldown FSM plus registered accept/reject pulses and the drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= READY;
      cool_r     <= {COOL_W{1'b0}};
      spawned_r  <= 1'b0;
      dropped_r  <= 1'b0;
      drop_cnt_r <= 8'd0;
    end else begin
      spawned_r <= accept_s;
      dropped_r <= reject_s;
      if (reject_s) begin
        drop_cnt_r <= sat_inc8(drop_cnt_r);
      end
      if (clear) begin
        state_r <= READY;
        cool_r  <= {COOL_W{1'b0}};
      end else begin
        case (state_r)
          READY: begin
            if (accept_s && (COOLDOWN != 0)) begin
              state_r <= COOL;
              cool_r  <= COOL_W'(COOLDOWN);
            end
          end
          COOL: begin
            if (tick) begin
              if (cool_r <= COOL_W'(1)) begin
                state_r <= READY;
                cool_r  <= {COOL_W{1'b0}};
              end else begin
                cool_r <= cool_r - COOL_W'(1);
              end
            end
          end
          default: begin
            state_r <= READY;
            cool_r  <= {COOL_W{1'b0}};
          end
        endcase
      end
    end
  end

  assign active   = active_s;
  assign spawned  = spawned_r;
  assign dropped  = dropped_r;
  assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_spawn_ctrl.sv
// Scoreboard bench for spawn_ctrl: dut 0 has LIFETIME=3/COOLDOWN=0, dut 1 has
// LIFETIME=600/COOLDOWN=2; every spawned/dropped pulse is matched to a queued expectation.
module tb_spawn_ctrl;

  typedef struct packed {
    logic        d;
    logic        sp;
    logic        dr;
    logic [3:0]  act;
    logic [31:0] typ;
    logic [7:0]  cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        dv_v    [2];
  logic [7:0]  data_v  [2];
  logic        tick_v  [2];
  logic [3:0]  desp_v  [2];
  logic        clear_v [2];
  logic [3:0]  active_v[2];
  logic [31:0] type_v  [2];
  logic        sp_v    [2];
  logic        dr_v    [2];
  logic [7:0]  cnt_v   [2];

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t mon_e;
  logic [46:0] mon_got;

  spawn_ctrl #(.N_SLOTS(4), .DATA_W(8), .LIFE_W(10), .LIFETIME(3), .COOLDOWN(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .data_valid(dv_v[0]), .data(data_v[0]), .tick(tick_v[0]),
    .despawn(desp_v[0]), .clear(clear_v[0]), .active(active_v[0]), .slot_type(type_v[0]),
    .spawned(sp_v[0]), .dropped(dr_v[0]), .drop_cnt(cnt_v[0]));

  spawn_ctrl #(.N_SLOTS(4), .DATA_W(8), .LIFE_W(10), .LIFETIME(600), .COOLDOWN(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .data_valid(dv_v[1]), .data(data_v[1]), .tick(tick_v[1]),
    .despawn(desp_v[1]), .clear(clear_v[1]), .active(active_v[1]), .slot_type(type_v[1]),
    .spawned(sp_v[1]), .dropped(dr_v[1]), .drop_cnt(cnt_v[1]));

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, got, want);
    end
  endtask

  task automatic push(input int d, input logic sp, input logic dr, input logic [3:0] act,
                      input logic [31:0] typ, input logic [7:0] cnt);
    exp_t e;
    e.d = 1'(d); e.sp = sp; e.dr = dr; e.act = act; e.typ = typ; e.cnt = cnt;
    q.push_back(e);
  endtask

  // Drives one cycle of inputs on dut d starting just after a rising edge.
  task automatic step(input int d, input logic dv, input logic [7:0] dt, input logic tk,
                      input logic [3:0] ds, input logic cl);
    dv_v[d] = dv; data_v[d] = dt; tick_v[d] = tk; desp_v[d] = ds; clear_v[d] = cl;
    @(posedge clk); #1;
    dv_v[d] = 1'b0; data_v[d] = 8'h00; tick_v[d] = 1'b0; desp_v[d] = 4'b0000; clear_v[d] = 1'b0;
  endtask

  task automatic req(input int d, input logic [7:0] v);
    step(d, 1'b1, v, 1'b0, 4'b0000, 1'b0);
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int d = 0; d < 2; d++) begin
        if (sp_v[d] || dr_v[d]) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse dut%0d: got spawned=%b dropped=%b, required no pulse",
                     d, sp_v[d], dr_v[d]);
          end else begin
            mon_e   = q.pop_front();
            mon_got = {1'(d), sp_v[d], dr_v[d], active_v[d], type_v[d], cnt_v[d]};
            if (mon_got !== mon_e) begin
              errors++;
              $display("FAIL pulse dut%0d: got {d,sp,dr,act,type,cnt}=%h required %h",
                       d, mon_got, 47'(mon_e));
            end
          end
        end
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      dv_v[d] = 1'b0; data_v[d] = 8'h00; tick_v[d] = 1'b0; desp_v[d] = 4'b0000; clear_v[d] = 1'b0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #12;
    chk("reset_a", {active_v[0], type_v[0], sp_v[0], dr_v[0], cnt_v[0]}, 64'd0);
    chk("reset_b", {active_v[1], type_v[1], sp_v[1], dr_v[1], cnt_v[1]}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First spawn lands in slot 0, then clear empties it.
    push(0, 1'b1, 1'b0, 4'b0001, 32'h0000_0005, 8'd0);
    req(0, 8'h05);
    step(0, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b1);
    chk("a_clear_basic", {active_v[0], type_v[0]}, 64'd0);

    // Lifetime 3: the tick coincident with the spawn is not counted.
    push(0, 1'b1, 1'b0, 4'b0001, 32'h0000_0007, 8'd0);
    step(0, 1'b1, 8'h07, 1'b1, 4'b0000, 1'b0);
    step(0, 1'b0, 8'h00, 1'b1, 4'b0000, 1'b0);
    chk("a_life_tick1", {active_v[0], type_v[0]}, {28'd0, 4'b0001, 32'h0000_0007});
    step(0, 1'b0, 8'h00, 1'b1, 4'b0000, 1'b0);
    chk("a_life_tick2", {active_v[0], type_v[0]}, {28'd0, 4'b0001, 32'h0000_0007});
    step(0, 1'b0, 8'h00, 1'b1, 4'b0000, 1'b0);
    chk("a_life_expire", {active_v[0], type_v[0]}, 64'd0);

    // Zero data word is not a request.
    req(0, 8'h00);
    chk("a_zero_data", {active_v[0], cnt_v[0]}, 64'd0);

    // Fill all four slots, then overflow and saturate the drop counter.
    push(0, 1'b1, 1'b0, 4'b0001, 32'h0000_0011, 8'd0); req(0, 8'h11);
    push(0, 1'b1, 1'b0, 4'b0011, 32'h0000_2211, 8'd0); req(0, 8'h22);
    push(0, 1'b1, 1'b0, 4'b0111, 32'h0033_2211, 8'd0); req(0, 8'h33);
    push(0, 1'b1, 1'b0, 4'b1111, 32'h4433_2211, 8'd0); req(0, 8'h44);
    push(0, 1'b0, 1'b1, 4'b1111, 32'h4433_2211, 8'd1); req(0, 8'h55);
    for (int k = 1; k <= 300; k++) begin
      push(0, 1'b0, 1'b1, 4'b1111, 32'h4433_2211, (k + 1 > 255) ? 8'd255 : 8'(k + 1));
      req(0, 8'h5A);
    end
    chk("a_drop_sat", {56'd0, cnt_v[0]}, 64'd255);

    // Despawn frees slots; a slot freed in the request cycle is not yet allocatable.
    step(0, 1'b0, 8'h00, 1'b0, 4'b1000, 1'b0);
    chk("a_despawn3", {active_v[0], type_v[0]}, {28'd0, 4'b0111, 32'h0033_2211});
    push(0, 1'b1, 1'b0, 4'b1101, 32'h6633_0011, 8'd255);
    step(0, 1'b1, 8'h66, 1'b0, 4'b0010, 1'b0);
    push(0, 1'b1, 1'b0, 4'b1111, 32'h6633_7711, 8'd255);
    req(0, 8'h77);
    step(0, 1'b0, 8'h00, 1'b1, 4'b0001, 1'b0);
    chk("a_despawn_tick", {active_v[0], type_v[0]}, {28'd0, 4'b1110, 32'h6633_7700});

    // Clear with a same-cycle request: no pulse, counter kept.
    step(0, 1'b1, 8'h88, 1'b0, 4'b0000, 1'b1);
    chk("a_clear_req", {active_v[0], type_v[0], cnt_v[0]}, {20'd0, 4'b0000, 32'd0, 8'd255});
    push(0, 1'b1, 1'b0, 4'b0001, 32'h0000_0099, 8'd255);
    req(0, 8'h99);

    // Cooldown of 2 ticks on dut 1.
    push(1, 1'b1, 1'b0, 4'b0001, 32'h0000_000A, 8'd0); req(1, 8'h0A);
    push(1, 1'b0, 1'b1, 4'b0001, 32'h0000_000A, 8'd1); req(1, 8'h0B);
    step(1, 1'b0, 8'h00, 1'b1, 4'b0000, 1'b0);
    push(1, 1'b0, 1'b1, 4'b0001, 32'h0000_000A, 8'd2); req(1, 8'h0C);
    step(1, 1'b0, 8'h00, 1'b1, 4'b0000, 1'b0);
    push(1, 1'b1, 1'b0, 4'b0011, 32'h0000_0D0A, 8'd2); req(1, 8'h0D);
    step(1, 1'b0, 8'h00, 1'b0, 4'b0000, 1'b1);
    chk("b_clear", {active_v[1], type_v[1], cnt_v[1]}, {20'd0, 4'b0000, 32'd0, 8'd2});
    push(1, 1'b1, 1'b0, 4'b0001, 32'h0000_000E, 8'd2); req(1, 8'h0E);

    // Asynchronous reset while cooling down.
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("b_reset_mid", {active_v[1], type_v[1], sp_v[1], dr_v[1], cnt_v[1]}, 64'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push(1, 1'b1, 1'b0, 4'b0001, 32'h0000_0021, 8'd0); req(1, 8'h21);

    @(negedge clk); #1;
    chk("pending_pulses", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
